// File: rtl/img2col_stream_pkg.sv
// Shared types, sizing helpers and default-geometry constants for img2col_stream.
package img2col_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Address width of a memory with the given number of words.
  function automatic int unsigned addr_width(input int unsigned depth);
    return bits_for(depth);
  endfunction

  // Number of window positions along one image axis.
  function automatic int unsigned calc_out_dim(input int unsigned img, input int unsigned k,
                                               input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  // Words per im2col window.
  function automatic int unsigned calc_win(input int unsigned k, input int unsigned ch_words);
    return k * k * ch_words;
  endfunction

  localparam int unsigned DEF_IMG_W    = 224;
  localparam int unsigned DEF_IMG_H    = 224;
  localparam int unsigned DEF_CH_WORDS = 4;
  localparam int unsigned DEF_K        = 3;
  localparam int unsigned DEF_STRIDE   = 1;

  localparam int unsigned OW  = calc_out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
  localparam int unsigned OH  = calc_out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);
  localparam int unsigned WIN = calc_win(DEF_K, DEF_CH_WORDS);

endpackage

// File: rtl/img2col_linebuf.sv
// Simple dual-port line-buffer RAM: one write port, one read port, 1-cycle read latency.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, valid the cycle after re
module img2col_linebuf
  import img2col_stream_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4 * 224 * 4,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/img2col_stream.sv
// Streaming im2col: buffers raster input rows in a (K+1)-row ring and emits
// K x K x CH_WORDS windows in (oy, ox, ky, kx, cw) order.
//   clk, reset (async, active-low), start (frame begin pulse)
//   s_axis_s2mm_tdata/tvalid/tready : raster input stream
//   mdata/mvalid/mready/mlast       : im2col output stream, mlast on the frame's final word
module img2col_stream
  import img2col_stream_pkg::*;
#(
  parameter int unsigned DW       = 64,
  parameter int unsigned IMG_W    = 224,
  parameter int unsigned IMG_H    = 224,
  parameter int unsigned CH_WORDS = 4,
  parameter int unsigned K        = 3,
  parameter int unsigned STRIDE   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] s_axis_s2mm_tdata,
  input  logic          s_axis_s2mm_tvalid,
  output logic          s_axis_s2mm_tready,
  output logic [DW-1:0] mdata,
  output logic          mvalid,
  input  logic          mready,
  output logic          mlast
);

  localparam int unsigned OUT_W     = calc_out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OUT_H     = calc_out_dim(IMG_H, K, STRIDE);
  localparam int unsigned ROW_WORDS = IMG_W * CH_WORDS;
  localparam int unsigned DEPTH     = (K + 1) * ROW_WORDS;
  localparam int unsigned AW        = addr_width(DEPTH);
  localparam int unsigned CWW       = bits_for(CH_WORDS);
  localparam int unsigned CLW       = bits_for(IMG_W);
  localparam int unsigned RW        = bits_for(IMG_H + K + 2);
  localparam int unsigned SW        = bits_for(K + 1);
  localparam int unsigned SSW       = bits_for(2 * K + 1);
  localparam int unsigned KW        = bits_for(K);
  localparam int unsigned OXW       = bits_for(OUT_W);
  localparam int unsigned OYW       = bits_for(OUT_H + 1);

  state_t state_q, state_d;

  // Write-side counters; wr_row also serves as the count of completed input rows.
  logic [RW-1:0]  wr_row;
  logic [CLW-1:0] wr_col;
  logic [CWW-1:0] wr_cw;
  logic [SW-1:0]  wr_slot;

  // Read-side window counters plus running bases that avoid multiplies and modulo.
  logic [OYW-1:0] rd_oy;
  logic [OXW-1:0] rd_ox;
  logic [KW-1:0]  rd_ky, rd_kx;
  logic [CWW-1:0] rd_cw;
  logic [RW-1:0]  rd_row_base;
  logic [CLW-1:0] rd_col_base;
  logic [SW-1:0]  rd_slot_base;

  // Output pipeline: RAM read in flight, skid entry, output register.
  logic          rd_pend, rd_pend_last;
  logic          skid_v, skid_last;
  logic [DW-1:0] skid_data;
  logic [DW-1:0] ram_q;

  logic           wr_en, rd_en, frame_clr, xfer_out;
  logic           in_open, rd_ok, room, rd_last_c;
  logic [1:0]     occ;
  logic [SSW-1:0] slot_sum, base_sum;
  logic [SW-1:0]  rd_slot, slot_base_next;
  logic [CLW-1:0] rd_col;
  logic [AW-1:0]  waddr, raddr;

  assign xfer_out = mvalid && mready;
  assign wr_en    = s_axis_s2mm_tvalid && s_axis_s2mm_tready;

  // Input may fill rows up to one beyond the window currently being read.
  assign in_open = (wr_row < RW'(IMG_H)) && (wr_row < rd_row_base + RW'(K + 1));

  // Items held or in flight after this cycle's transfer must stay within out reg + skid.
  assign occ  = 2'(mvalid) + 2'(skid_v) + 2'(rd_pend) - 2'(xfer_out);
  assign room = occ < 2'd2;

  // A window row is readable once all its input rows are complete.
  assign rd_ok = (rd_oy < OYW'(OUT_H)) && (wr_row >= rd_row_base + RW'(K)) && room;

  assign rd_last_c = (rd_oy == OYW'(OUT_H - 1)) && (rd_ox == OXW'(OUT_W - 1)) &&
                     (rd_ky == KW'(K - 1)) && (rd_kx == KW'(K - 1)) &&
                     (rd_cw == CWW'(CH_WORDS - 1));

  // Ring-slot of the current kernel row and next-row base slot, wrapped at K+1.
  always_comb begin
    slot_sum       = SSW'(rd_slot_base) + SSW'(rd_ky);
    rd_slot        = (slot_sum >= SSW'(K + 1)) ? SW'(slot_sum - SSW'(K + 1)) : SW'(slot_sum);
    base_sum       = SSW'(rd_slot_base) + SSW'(STRIDE);
    slot_base_next = (base_sum >= SSW'(K + 1)) ? SW'(base_sum - SSW'(K + 1)) : SW'(base_sum);
  end

  assign rd_col = rd_col_base + CLW'(rd_kx);
  assign waddr  = AW'(wr_slot) * AW'(ROW_WORDS) + AW'(wr_col) * AW'(CH_WORDS) + AW'(wr_cw);
  assign raddr  = AW'(rd_slot) * AW'(ROW_WORDS) + AW'(rd_col) * AW'(CH_WORDS) + AW'(rd_cw);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (xfer_out && mlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-dependent controls
  always_comb begin
    s_axis_s2mm_tready = 1'b0;
    rd_en              = 1'b0;
    frame_clr          = 1'b0;
    case (state_q)
      IDLE: frame_clr = start;
      RUN: begin
        s_axis_s2mm_tready = in_open;
        rd_en              = rd_ok;
      end
      default: ;
    endcase
  end

  // Raster write counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_row  <= '0;
      wr_col  <= '0;
      wr_cw   <= '0;
      wr_slot <= '0;
    end else if (frame_clr) begin
      wr_row  <= '0;
      wr_col  <= '0;
      wr_cw   <= '0;
      wr_slot <= '0;
    end else if (wr_en) begin
      if (wr_cw == CWW'(CH_WORDS - 1)) begin
        wr_cw <= '0;
        if (wr_col == CLW'(IMG_W - 1)) begin
          wr_col  <= '0;
          wr_row  <= wr_row + RW'(1);
          wr_slot <= (wr_slot == SW'(K)) ? '0 : wr_slot + SW'(1);
        end else begin
          wr_col <= wr_col + CLW'(1);
        end
      end else begin
        wr_cw <= wr_cw + CWW'(1);
      end
    end
  end

  // Window read counters, innermost channel word first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_oy        <= '0;
      rd_ox        <= '0;
      rd_ky        <= '0;
      rd_kx        <= '0;
      rd_cw        <= '0;
      rd_row_base  <= '0;
      rd_col_base  <= '0;
      rd_slot_base <= '0;
    end else if (frame_clr) begin
      rd_oy        <= '0;
      rd_ox        <= '0;
      rd_ky        <= '0;
      rd_kx        <= '0;
      rd_cw        <= '0;
      rd_row_base  <= '0;
      rd_col_base  <= '0;
      rd_slot_base <= '0;
    end else if (rd_en) begin
      if (rd_cw == CWW'(CH_WORDS - 1)) begin
        rd_cw <= '0;
        if (rd_kx == KW'(K - 1)) begin
          rd_kx <= '0;
          if (rd_ky == KW'(K - 1)) begin
            rd_ky <= '0;
            if (rd_ox == OXW'(OUT_W - 1)) begin
              rd_ox        <= '0;
              rd_col_base  <= '0;
              rd_oy        <= rd_oy + OYW'(1);
              rd_row_base  <= rd_row_base + RW'(STRIDE);
              rd_slot_base <= slot_base_next;
            end else begin
              rd_ox       <= rd_ox + OXW'(1);
              rd_col_base <= rd_col_base + CLW'(STRIDE);
            end
          end else begin
            rd_ky <= rd_ky + KW'(1);
          end
        end else begin
          rd_kx <= rd_kx + KW'(1);
        end
      end else begin
        rd_cw <= rd_cw + CWW'(1);
      end
    end
  end

  // Output register with one skid entry; RAM data lands in whichever is free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mvalid       <= 1'b0;
      mlast        <= 1'b0;
      mdata        <= '0;
      skid_v       <= 1'b0;
      skid_last    <= 1'b0;
      skid_data    <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else if (frame_clr) begin
      mvalid       <= 1'b0;
      mlast        <= 1'b0;
      skid_v       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && rd_last_c;
      if (!mvalid || xfer_out) begin
        if (skid_v) begin
          mdata     <= skid_data;
          mlast     <= skid_last;
          mvalid    <= 1'b1;
          skid_v    <= rd_pend;
          skid_data <= ram_q;
          skid_last <= rd_pend_last;
        end else if (rd_pend) begin
          mdata  <= ram_q;
          mlast  <= rd_pend_last;
          mvalid <= 1'b1;
        end else begin
          mvalid <= 1'b0;
          mlast  <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_v    <= 1'b1;
        skid_data <= ram_q;
        skid_last <= rd_pend_last;
      end
    end
  end

  img2col_linebuf #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_linebuf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(s_axis_s2mm_tdata),
    .re   (rd_en),
    .raddr(raddr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_img2col_stream.sv
// Directed bench for img2col_stream: three geometries (4x4 K3 S1, 5x5 K3 S2,
// 7x6x2ch K3 S1) sharing one stimulus driver selected by 'sel'.
module tb_img2col_stream;

  localparam int unsigned DW        = 16;
  localparam int          CYC_LIMIT = 4000;
  localparam int          STALL     = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int            sel;
  logic          start_s, tvalid_s, mready_s;
  logic [DW-1:0] tdata_s;

  logic          tr0, mv0, ml0, tr1, mv1, ml1, tr2, mv2, ml2;
  logic [DW-1:0] md0, md1, md2;
  logic          o_tready, o_mvalid, o_mlast;
  logic [DW-1:0] o_mdata;

  int n_tests = 0;
  int n_fail  = 0;
  int got[$];

  img2col_stream #(.DW(DW), .IMG_W(4), .IMG_H(4), .CH_WORDS(1), .K(3), .STRIDE(1)) u_base (
    .clk(clk), .reset(reset), .start(start_s && sel == 0),
    .s_axis_s2mm_tdata(tdata_s), .s_axis_s2mm_tvalid(tvalid_s && sel == 0),
    .s_axis_s2mm_tready(tr0), .mdata(md0), .mvalid(mv0),
    .mready(sel == 0 ? mready_s : 1'b1), .mlast(ml0));

  img2col_stream #(.DW(DW), .IMG_W(5), .IMG_H(5), .CH_WORDS(1), .K(3), .STRIDE(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start_s && sel == 1),
    .s_axis_s2mm_tdata(tdata_s), .s_axis_s2mm_tvalid(tvalid_s && sel == 1),
    .s_axis_s2mm_tready(tr1), .mdata(md1), .mvalid(mv1),
    .mready(sel == 1 ? mready_s : 1'b1), .mlast(ml1));

  img2col_stream #(.DW(DW), .IMG_W(7), .IMG_H(6), .CH_WORDS(2), .K(3), .STRIDE(1)) u_rnd (
    .clk(clk), .reset(reset), .start(start_s && sel == 2),
    .s_axis_s2mm_tdata(tdata_s), .s_axis_s2mm_tvalid(tvalid_s && sel == 2),
    .s_axis_s2mm_tready(tr2), .mdata(md2), .mvalid(mv2),
    .mready(sel == 2 ? mready_s : 1'b1), .mlast(ml2));

  always_comb begin
    case (sel)
      1: begin o_tready = tr1; o_mvalid = mv1; o_mlast = ml1; o_mdata = md1; end
      2: begin o_tready = tr2; o_mvalid = mv2; o_mlast = ml2; o_mdata = md2; end
      default: begin o_tready = tr0; o_mvalid = mv0; o_mlast = ml0; o_mdata = md0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Geometry per selected DUT: {W, H, CH, K, S}
  function automatic void geom(input int d, output int w, output int h, output int ch,
                               output int k, output int s);
    case (d)
      1:       begin w = 5; h = 5; ch = 1; k = 3; s = 2; end
      2:       begin w = 7; h = 6; ch = 2; k = 3; s = 1; end
      default: begin w = 4; h = 4; ch = 1; k = 3; s = 1; end
    endcase
  endfunction

  function automatic logic [DW-1:0] data_of(input int d, input int i);
    return (d == 2) ? DW'(i * 3 + 1) : DW'(i);
  endfunction

  function automatic int frame_in(input int d);
    int w, h, ch, k, s;
    geom(d, w, h, ch, k, s);
    return w * h * ch;
  endfunction

  function automatic int frame_out(input int d);
    int w, h, ch, k, s;
    geom(d, w, h, ch, k, s);
    return ((w - k) / s + 1) * ((h - k) / s + 1) * k * k * ch;
  endfunction

  // Raster index of the input word that output word n must carry.
  function automatic int ref_idx(input int d, input int n);
    int w, h, ch, k, s, ow, t, cw, kx, ky, ox, oy;
    geom(d, w, h, ch, k, s);
    ow = (w - k) / s + 1;
    cw = n % ch;  t = n / ch;
    kx = t % k;   t = t / k;
    ky = t % k;   t = t / k;
    ox = t % ow;  oy = t / ow;
    return ((oy * s + ky) * w + ox * s + kx) * ch + cw;
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  // mode 0: mready=1, 1: random mready, 2: stall STALL cycles after the first output
  task automatic run_frame(input int d, input int mode, input int restart_at,
                           input int abort_at, input int stall_in_exp);
    int n_in, n_out, nin, nout, stall_cnt;
    logic prev_hold, prev_last, in_hs;
    logic [DW-1:0] prev_data;
    n_in = frame_in(d);
    n_out = frame_out(d);
    sel = d;
    got.delete();
    nin = 0; nout = 0; stall_cnt = 0;
    prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    start_s = 1'b1; tvalid_s = 1'b1; tdata_s = data_of(d, 0); mready_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int cyc = 0; cyc < CYC_LIMIT && nout < n_out; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        check("hold_mvalid", 32'(o_mvalid), 32'(1));
        check("hold_mdata", 32'(o_mdata), 32'(prev_data));
        check("hold_mlast", 32'(o_mlast), 32'(prev_last));
      end
      if (o_mvalid && mready_s) begin
        got.push_back(int'(o_mdata));
        check("mlast", 32'(o_mlast), 32'(nout == n_out - 1));
        nout++;
      end
      prev_hold = o_mvalid && !mready_s;
      prev_data = o_mdata;
      prev_last = o_mlast;
      in_hs = tvalid_s && o_tready;
      @(posedge clk); #1;
      if (in_hs) nin++;
      tdata_s = data_of(d, nin);
      start_s = (cyc == restart_at);
      if (cyc == abort_at) begin
        reset = 1'b0;
        start_s = 1'b0;
        @(negedge clk);
        check("abort_mvalid", 32'(o_mvalid), 32'(0));
        check("abort_tready", 32'(o_tready), 32'(0));
        check("abort_mlast", 32'(o_mlast), 32'(0));
        reset = 1'b1;
        tvalid_s = 1'b0;
        mready_s = 1'b1;
        return;
      end
      case (mode)
        1: mready_s = 1'($urandom_range(0, 1));
        2: begin
          if (nout >= 1 && stall_cnt < STALL) begin
            mready_s = 1'b0;
            stall_cnt++;
            if (stall_cnt == STALL) begin
              check("stall_in_count", 32'(nin), 32'(stall_in_exp));
              check("stall_tready", 32'(o_tready), 32'(0));
            end
          end else begin
            mready_s = 1'b1;
          end
        end
        default: mready_s = 1'b1;
      endcase
    end
    start_s = 1'b0;
    mready_s = 1'b1;
    check("out_count", 32'(nout), 32'(n_out));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_mvalid", 32'(o_mvalid), 32'(0));
      check("idle_tready", 32'(o_tready), 32'(0));
    end
    check("in_count", 32'(nin), 32'(n_in));
    tvalid_s = 1'b0;
    for (int n = 0; n < got.size(); n++)
      check("model", 32'(got[n]), 32'(data_of(d, ref_idx(d, n))));
  endtask

  task automatic check_base_hand();
    int first9 [9];
    int win11 [9];
    first9 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    win11  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    for (int i = 0; i < 9; i++) check("base_first9", 32'(got_at(i)), 32'(first9[i]));
    for (int i = 0; i < 9; i++) check("base_win11", 32'(got_at(27 + i)), 32'(win11[i]));
    check("base_total", 32'(got.size()), 32'(36));
  endtask

  initial begin
    int s2exp [4];
    s2exp = '{12, 13, 14, 17};
    sel = 0; start_s = 1'b0; tvalid_s = 1'b0; mready_s = 1'b1; tdata_s = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      @(negedge clk);
      check("rst_tready", 32'(o_tready), 32'(0));
      check("rst_mvalid", 32'(o_mvalid), 32'(0));
      check("rst_mlast", 32'(o_mlast), 32'(0));
      check("rst_mdata", 32'(o_mdata), 32'(0));
    end
    @(negedge clk);
    reset = 1'b1;

    run_frame(0, 0, -1, -1, 0);
    check_base_hand();

    run_frame(0, 0, 6, -1, 0);
    check_base_hand();

    run_frame(0, 0, -1, 10, 0);
    run_frame(0, 0, -1, -1, 0);
    check_base_hand();

    run_frame(1, 0, -1, -1, 0);
    for (int i = 0; i < 4; i++) check("s2_win11", 32'(got_at(27 + i)), 32'(s2exp[i]));

    run_frame(2, 1, -1, -1, 0);
    run_frame(2, 2, -1, -1, 56);
    run_frame(0, 2, -1, -1, 16);
    check_base_hand();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
